// File: rtl/nibble_serial_sub_ctrl.sv
// rtl/nibble_serial_sub_ctrl.sv - wide A-B-bin subtraction streamed one nibble per cycle
// through an external combinational 4-bit ripple-borrow subtractor.
module nibble_serial_sub_ctrl #(
   parameter int NIBBLES = 4,
   parameter int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [3:0]   sub_a,
   output logic [3:0]   sub_b,
   output logic         sub_bin,
   input  logic [3:0]   sub_D,
   input  logic [3:0]   sub_B,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow_out
);

   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic               brw_q, brw_d;
   logic [W-1:0]       diff_q, diff_d;
   logic               bout_q, bout_d;

   // Only the final borrow of the 4-bit chain matters to the sequencer.
   logic [2:0]         unused_sub_b;
   assign unused_sub_b = sub_B[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      sub_a   = 4'd0;
      sub_b   = 4'd0;
      sub_bin = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            sub_a   = a_q[4*idx_q +: 4];
            sub_b   = b_q[4*idx_q +: 4];
            sub_bin = brw_q;
            diff_d[4*idx_q +: 4] = sub_D;
            brw_d   = sub_B[3];
            if (idx_q == LAST_IDX) begin
               // Index wraps to 0 so it never leaves the legal nibble range.
               idx_d   = '0;
               bout_d  = sub_B[3];
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// tb/tb_nibble_serial_sub_ctrl.sv - randomized self-checking bench for nibble_serial_sub_ctrl
// (4-nibble and 1-nibble instances, each wrapped around a behavioural 4-bit subtractor).
module tb_nibble_serial_sub_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   int          n_checks = 0;
   int          n_pass   = 0;

   logic        start4, bin4, start1, bin1;
   logic [15:0] a4, b4;
   logic [3:0]  a1, b1;

   logic [3:0]  sa4, sb4, sD4, sB4, sa1, sb1, sD1, sB1;
   logic        sbin4, sbin1, busy4, busy1, done4, done1, bo4, bo1;
   logic [15:0] diff4;
   logic [3:0]  diff1;

   logic [3:0]  c_sa, c_sb;
   logic        c_sbin, c_busy, c_done, c_bo;
   logic [15:0] c_diff;

   always #5 clk = ~clk;

   nibble_serial_sub_ctrl #(.NIBBLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .sub_a(sa4), .sub_b(sb4), .sub_bin(sbin4), .sub_D(sD4), .sub_B(sB4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
   );

   nibble_serial_sub_ctrl #(.NIBBLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .sub_a(sa1), .sub_b(sb1), .sub_bin(sbin1), .sub_D(sD1), .sub_B(sB1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   function automatic logic [7:0] sub4(input logic [3:0] x, input logic [3:0] y, input logic bi);
      logic [3:0] d;
      logic [3:0] ch;
      logic       br;
      br = bi;
      for (int i = 0; i < 4; i++) begin
         d[i]  = x[i] ^ y[i] ^ br;
         br    = (~x[i] & (y[i] | br)) | (y[i] & br);
         ch[i] = br;
      end
      return {ch, d};
   endfunction

   always_comb {sB4, sD4} = sub4(sa4, sb4, sbin4);
   always_comb {sB1, sD1} = sub4(sa1, sb1, sbin1);

   always_comb begin
      if (sel) begin
         c_sa = sa1; c_sb = sb1; c_sbin = sbin1; c_busy = busy1;
         c_done = done1; c_bo = bo1; c_diff = {12'd0, diff1};
      end else begin
         c_sa = sa4; c_sb = sb4; c_sbin = sbin4; c_busy = busy4;
         c_done = done4; c_bo = bo4; c_diff = diff4;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic drive(input bit which, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input logic st);
      if (which) begin
         a1 = a[3:0]; b1 = b[3:0]; bin1 = bi; start1 = st;
      end else begin
         a4 = a; b4 = b; bin4 = bi; start4 = st;
      end
   endtask

   // One full operation; operands are scrambled while running to prove they were latched.
   task automatic run_op(input bit which, input logic [15:0] a, input logic [15:0] b, input logic bi);
      int          n;
      logic [63:0] mask, lo, ea, eb_, ed;
      logic        ebo;
      n    = which ? 1 : 4;
      mask = (64'd1 << (4 * n)) - 1;
      ea   = {48'd0, a} & mask;
      eb_  = {48'd0, b} & mask;
      ed   = (ea - eb_ - {63'd0, bi}) & mask;
      ebo  = ea < (eb_ + {63'd0, bi});
      sel  = which;
      @(negedge clk);
      drive(which, a, b, bi, 1'b1);
      @(negedge clk);
      drive(which, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      for (int k = 0; k < n; k++) begin
         lo = (64'd1 << (4 * k)) - 1;
         check("busy_run", {63'd0, c_busy}, 64'd1);
         check("sub_a", {60'd0, c_sa}, (ea >> (4 * k)) & 64'hF);
         check("sub_b", {60'd0, c_sb}, (eb_ >> (4 * k)) & 64'hF);
         check("sub_bin", {63'd0, c_sbin}, {63'd0, (ea & lo) < ((eb_ & lo) + {63'd0, bi})});
         check("done_early", {63'd0, c_done}, 64'd0);
         drive(which, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
         @(negedge clk);
      end
      check("done", {63'd0, c_done}, 64'd1);
      check("busy_done", {63'd0, c_busy}, 64'd0);
      check("diff", {48'd0, c_diff}, ed);
      check("borrow_out", {63'd0, c_bo}, {63'd0, ebo});
      check("sub_a_done", {59'd0, c_sbin, c_sa}, 64'd0);
      @(negedge clk);
      check("done_1cyc", {63'd0, c_done}, 64'd0);
      check("diff_hold", {48'd0, c_diff}, ed);
   endtask

   initial begin
      int dones;
      sel = 1'b0;
      rst_n = 1'b0;
      drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      drive(1'b1, 16'd0, 16'd0, 1'b0, 1'b0);
      #12;
      check("rst_busy", {62'd0, busy4, busy1}, 64'd0);
      check("rst_done", {62'd0, done4, done1}, 64'd0);
      check("rst_diff", {44'd0, diff4, diff1}, 64'd0);
      check("rst_bo", {62'd0, bo4, bo1}, 64'd0);
      check("rst_sub", {54'd0, sa4, sb4, sbin4, sbin1}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 16'h1234, 16'h0123, 1'b0);
      run_op(1'b0, 16'h0000, 16'h0001, 1'b0);
      run_op(1'b0, 16'h8000, 16'h8000, 1'b1);
      run_op(1'b0, 16'hFFFF, 16'h0000, 1'b0);
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);

      // Start held continuously: one done every N+2 cycles.
      sel = 1'b0;
      @(negedge clk);
      drive(1'b0, 16'h00FF, 16'h000F, 1'b0, 1'b1);
      dones = 0;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (done4) begin
            dones++;
            check("held_diff", {48'd0, diff4}, 64'h00F0);
         end
      end
      check("held_done_cnt", 64'(dones), 64'd3);
      start4 = 1'b0;
      repeat (6) @(negedge clk);

      // Reset mid-RUN after two nibbles captured.
      drive(1'b0, 16'hABCD, 16'h1111, 1'b0, 1'b1);
      @(negedge clk);
      start4 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {63'd0, busy4}, 64'd0);
      check("mid_rst_out", {47'd0, diff4, bo4}, 64'd0);
      check("mid_rst_sub", {55'd0, sa4, sb4, sbin4}, 64'd0);
      dones = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done4) dones++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done4) dones++;
      end
      check("mid_rst_nodone", 64'(dones), 64'd0);
      run_op(1'b0, 16'h5555, 16'h1234, 1'b1);

      run_op(1'b1, 16'h0003, 16'h0005, 1'b0);
      run_op(1'b1, 16'h000F, 16'h000F, 1'b1);

      for (int i = 0; i < 20; i++)
         run_op(1'($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom), 1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
